audio_out_stage: RTL and testbench
==================================

// Module: audio_out_stage
// PURPOSE
//  Output conditioning stage directly downstream of the moving-average filter, feeding the codec write port.
//  Applies a per-sample power-of-two gain with signed saturation and buffers samples in a 2-deep stall pipeline against write_ready.
//  Keeps per-channel peak meters (hold + decay) and sticky clip flags for the status/LED logic.
// PARAMETERS
//  DATA_WIDTH    24   sample width, signed two's complement, both channels
//  HOLD_SAMPLES  64   accepted samples a new peak is held before decay starts (>=1)
//  DECAY_SHIFT   4    decay step per accepted sample after hold: peak -= peak >>> DECAY_SHIFT
// PORTS
//  clk             in   1    system clock
//  reset_n         in   1    asynchronous reset, active-low
//  in_valid        in   1    filter presents a stereo sample
//  in_left         in   24   signed left sample from filter
//  in_right        in   24   signed right sample from filter
//  in_ready        out  1    stage accepts sample this cycle (in_valid & in_ready = accept)
//  gain_sel        in   3    left-shift amount 0..7 applied to both channels
//  write_ready     in   1    codec FIFO has space
//  write           out  1    sample presented to codec is consumed this cycle
//  writedata_left  out  24   saturated left output
//  writedata_right out  24   saturated right output
//  peak_left       out  23   |left| peak meter, unsigned
//  peak_right      out  23   |right| peak meter, unsigned
//  clip_left       out  1    sticky: left saturated since last clear
//  clip_right      out  1    sticky: right saturated since last clear
//  clip_clr        in   1    one-cycle clear of both clip flags
// BEHAVIOUR
//  - Reset (async, reset_n=0): both stage valid bits 0, all data regs 0, write=0, in_ready=1, peaks 0, hold counters 0, clip flags 0.
//    Reset asserted mid-stream drops in-flight samples; no partial output after release.
//  - Pipeline: S1 = gain+saturate register, S2 = output register. Each stage holds {valid, left, right, sat flags}.
//  - write = S2.valid & write_ready. writedata_* = S2 data (held stable while S2.valid & ~write_ready).
//  - S2 advances when ~S2.valid | write_ready; S1 advances when ~S1.valid | S2 advances.
//  - in_ready = ~S1.valid | S2 advances (combinational from write_ready). No bubbles: full throughput 1 sample/cycle.
//  - Latency: accepted sample appears on writedata 2 cycles later with write_ready held high.
//  - Backpressure: with write_ready=0 the stage absorbs exactly 2 samples, then in_ready=0; no sample lost or duplicated.
//  - Gain: gain_sel sampled at acceptance into S1; x' = x <<< gain_sel computed at DATA_WIDTH+7 bits,
//    saturated to [-2^23, 2^23-1] (0x800000 / 0x7FFFFF). gain_sel change affects only later-accepted samples.
//  - Clip: clip_* set when a saturated sample is written (write=1). clip_clr clears; set and clear same cycle -> set wins.
//  - Peak meter, updated only on write=1, per channel: a = |x| with 0x800000 mapped to 0x7FFFFF.
//    a >= peak: peak<=a, hold<=HOLD_SAMPLES. else hold!=0: hold<=hold-1. else peak<=peak-(peak>>DECAY_SHIFT).
//    Decay stops at values < 2^DECAY_SHIFT (step 0); peak never underflows.
//  - Hold counter width = $clog2(HOLD_SAMPLES+1); no wrap.
// CONFIGURATION
//  CLIP_COUNT_EN defined: adds outputs clip_count_left/right [15:0], incremented per written saturated sample,
//    saturating at 0xFFFF, cleared by clip_clr (clear wins over increment same cycle), reset to 0.
//  CLIP_COUNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 reset_n=0 with random inputs -> write=0, in_ready=1, writedata/peaks/clips=0; release -> idle, no write.
//  2 gain_sel=0, write_ready=1, stream L=0x000200,R=-0x000200 -> identical values on writedata exactly 2 cycles later, write=1.
//  3 gain_sel=3, L=0x200000, R=-0x100001 -> writedata_left=0x7FFFFF, writedata_right=0x800000, clip_left=clip_right=1 after write.
//  4 continuous in_valid, write_ready=0 for 5 cycles -> in_ready falls after 2 accepts; on release all samples exit in order, none lost.
//  5 one sample |L|=0x400000 then zeros, HOLD_SAMPLES=64, DECAY_SHIFT=4 -> peak 0x400000 for 64 writes, then 0x3C0000, 0x384000...
//  6 clip_clr coincident with saturated write -> clip stays 1; clip_clr alone -> 0; reset_n pulse mid-backpressure -> S1/S2 flushed.

Source files
------------

// File: rtl/audio_out_stage.sv
// audio_out_stage: codec output conditioning.
// Power-of-two gain with signed saturation, 2-deep stall pipeline against
// write_ready, per-channel peak meters (hold + decay), and sticky clip flags.
// Optional: define CLIP_COUNT_EN to add saturating per-channel clip counters.
module audio_out_stage #(
    parameter int DATA_WIDTH   = 24,
    parameter int HOLD_SAMPLES = 64,
    parameter int DECAY_SHIFT  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    output logic                  in_ready,
    input  logic [2:0]            gain_sel,
    input  logic                  write_ready,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] writedata_left,
    output logic [DATA_WIDTH-1:0] writedata_right,
    output logic [DATA_WIDTH-2:0] peak_left,
    output logic [DATA_WIDTH-2:0] peak_right,
    output logic                  clip_left,
    output logic                  clip_right,
    input  logic                  clip_clr
`ifdef CLIP_COUNT_EN
    ,
    output logic [15:0]           clip_count_left,
    output logic [15:0]           clip_count_right
`endif
);

    localparam int EW = DATA_WIDTH + 7;
    localparam int PW = DATA_WIDTH - 1;
    localparam int HW = $clog2(HOLD_SAMPLES + 1);

    // Returns {saturated, value}: sign-extend, shift, clamp when the top bits
    // of the widened product are not all copies of the result sign bit.
    function automatic logic [DATA_WIDTH:0] f_gain_sat(input logic [DATA_WIDTH-1:0] x,
                                                       input logic [2:0] sh);
        logic [EW-1:0] ext;
        logic [EW-1:0] shifted;
        logic [7:0]    top;
        ext     = {{7{x[DATA_WIDTH-1]}}, x};
        shifted = ext << sh;
        top     = shifted[EW-1:DATA_WIDTH-1];
        if (top == '0 || top == '1)
            return {1'b0, shifted[DATA_WIDTH-1:0]};
        else if (shifted[EW-1])
            return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    // Magnitude with the most negative code folded onto full scale.
    function automatic logic [PW-1:0] f_abs(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] neg;
        neg = -x;
        if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}})
            return '1;
        else if (x[DATA_WIDTH-1])
            return neg[PW-1:0];
        else
            return x[PW-1:0];
    endfunction

    logic                  r_s1_valid, r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s1_left, r_s1_right, r_s2_left, r_s2_right;
    logic [1:0]            r_s1_sat, r_s2_sat;
    logic [PW-1:0]         r_peak [2];
    logic [HW-1:0]         r_hold [2];
    logic [1:0]            r_clip;

    logic                  w_s2_adv, w_s1_adv, w_write;
    logic [DATA_WIDTH:0]   w_gl, w_gr;
    logic [PW-1:0]         w_abs [2];

    assign w_s2_adv = ~r_s2_valid | write_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign w_write  = r_s2_valid & write_ready;
    assign w_gl     = f_gain_sat(in_left, gain_sel);
    assign w_gr     = f_gain_sat(in_right, gain_sel);

    assign in_ready        = w_s1_adv;
    assign write           = w_write;
    assign writedata_left  = r_s2_left;
    assign writedata_right = r_s2_right;
    assign peak_left       = r_peak[0];
    assign peak_right      = r_peak[1];
    assign clip_left       = r_clip[0];
    assign clip_right      = r_clip[1];

    // Magnitudes of the sample currently presented to the codec.
    always_comb begin
        w_abs[0] = f_abs(r_s2_left);
        w_abs[1] = f_abs(r_s2_right);
    end

    // Two-stage pipeline: S1 captures gained/saturated input, S2 drives the codec.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_left  <= '0;
            r_s1_right <= '0;
            r_s2_left  <= '0;
            r_s2_right <= '0;
            r_s1_sat   <= '0;
            r_s2_sat   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_left  <= w_gl[DATA_WIDTH-1:0];
                    r_s1_right <= w_gr[DATA_WIDTH-1:0];
                    r_s1_sat   <= {w_gr[DATA_WIDTH], w_gl[DATA_WIDTH]};
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_left  <= r_s1_left;
                    r_s2_right <= r_s1_right;
                    r_s2_sat   <= r_s1_sat;
                end
            end
        end
    end

    // Peak meters and sticky clip flags, updated per written sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_peak[ch] <= '0;
                r_hold[ch] <= '0;
            end
            r_clip <= '0;
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (w_write) begin
                    if (w_abs[ch] >= r_peak[ch]) begin
                        r_peak[ch] <= w_abs[ch];
                        r_hold[ch] <= HW'(HOLD_SAMPLES);
                    end else if (r_hold[ch] != '0) begin
                        r_hold[ch] <= r_hold[ch] - 1'b1;
                    end else begin
                        r_peak[ch] <= r_peak[ch] - (r_peak[ch] >> DECAY_SHIFT);
                    end
                end
                if (w_write && r_s2_sat[ch])
                    r_clip[ch] <= 1'b1;
                else if (clip_clr)
                    r_clip[ch] <= 1'b0;
            end
        end
    end

`ifdef CLIP_COUNT_EN
    logic [15:0] r_cnt [2];

    assign clip_count_left  = r_cnt[0];
    assign clip_count_right = r_cnt[1];

    // Saturating clip counters; clear has priority over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned ch = 0; ch < 2; ch++)
                r_cnt[ch] <= '0;
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (clip_clr)
                    r_cnt[ch] <= '0;
                else if (w_write && r_s2_sat[ch] && r_cnt[ch] != 16'hFFFF)
                    r_cnt[ch] <= r_cnt[ch] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_audio_out_stage.sv
// Directed self-checking bench for audio_out_stage (default parameters).
module tb_audio_out_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [23:0] in_left, in_right;
    logic        in_ready;
    logic [2:0]  gain_sel;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left, writedata_right;
    logic [22:0] peak_left, peak_right;
    logic        clip_left, clip_right;
    logic        clip_clr;
`ifdef CLIP_COUNT_EN
    logic [15:0] clip_count_left, clip_count_right;
`endif

    int checks   = 0;
    int failures = 0;

    audio_out_stage #(.DATA_WIDTH(24), .HOLD_SAMPLES(64), .DECAY_SHIFT(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_left         (in_left),
        .in_right        (in_right),
        .in_ready        (in_ready),
        .gain_sel        (gain_sel),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .peak_left       (peak_left),
        .peak_right      (peak_right),
        .clip_left       (clip_left),
        .clip_right      (clip_right),
        .clip_clr        (clip_clr)
`ifdef CLIP_COUNT_EN
        ,
        .clip_count_left (clip_count_left),
        .clip_count_right(clip_count_right)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  g;
        logic [23:0] l, r, el, er;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_left     = '0;
        in_right    = '0;
        gain_sel    = '0;
        write_ready = 1'b1;
        clip_clr    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    logic [23:0] sent [$];
    logic [23:0] got [$];
    logic        acc, wr;
    int          k, nw, errs;

    initial begin
        //        gain  left        right       exp left    exp right
        vecs[0] = '{3'd0, 24'h000200, 24'hFFFE00, 24'h000200, 24'hFFFE00};
        vecs[1] = '{3'd3, 24'h200000, 24'hEFFFFF, 24'h7FFFFF, 24'h800000};
        vecs[2] = '{3'd1, 24'h3FFFFF, 24'hC00000, 24'h7FFFFE, 24'h800000};
        vecs[3] = '{3'd7, 24'h000001, 24'hFFFFFF, 24'h000080, 24'hFFFF80};
        vecs[4] = '{3'd7, 24'h010000, 24'hFF0000, 24'h7FFFFF, 24'h800000};
        vecs[5] = '{3'd0, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000};
        vecs[6] = '{3'd2, 24'h123456, 24'h000000, 24'h48D158, 24'h000000};
        vecs[7] = '{3'd4, 24'h080000, 24'hF80000, 24'h7FFFFF, 24'h800000};

        // Reset with random inputs applied.
        reset_n     = 1'b0;
        in_valid    = 1'($urandom);
        in_left     = 24'($urandom);
        in_right    = 24'($urandom);
        gain_sel    = 3'($urandom);
        write_ready = 1'($urandom);
        clip_clr    = 1'($urandom);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_write", 32'(write), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wd_left", 32'(writedata_left), 32'd0);
        check("rst_wd_right", 32'(writedata_right), 32'd0);
        check("rst_peaks", 32'({peak_left, peak_right}), 32'd0);
        check("rst_clips", 32'({clip_left, clip_right}), 32'd0);
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        write_ready = 1'b1;
        clip_clr    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_write", 32'(write), 32'd0);
            @(posedge clk); #1;
        end

        // Table-driven gain/saturation stream with 2-cycle latency.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                gain_sel = vecs[i].g;
                in_left  = vecs[i].l;
                in_right = vecs[i].r;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 2) begin
                check("lat_nowrite", 32'(write), 32'd0);
            end else begin
                check("vec_write", 32'(write), 32'd1);
                check("vec_left", 32'(writedata_left), 32'(vecs[i-2].el));
                check("vec_right", 32'(writedata_right), 32'(vecs[i-2].er));
            end
            @(posedge clk); #1;
        end
        check("clip_after_stream", 32'({clip_left, clip_right}), 32'd3);

        // Backpressure: absorb exactly two, then deliver all in order.
        do_reset();
        write_ready = 1'b0;
        k = 1;
        in_valid = 1'b1;
        in_left  = 24'(k);
        in_right = 24'(-k);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent.push_back(in_left);
            if (write) got.push_back(writedata_left);
            @(posedge clk); #1;
            if (acc) begin k++; in_left = 24'(k); in_right = 24'(-k); end
        end
        check("bp_accepts", 32'(sent.size()), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_no_write", 32'(got.size()), 32'd0);
        write_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent.push_back(in_left);
            if (write) got.push_back(writedata_left);
            @(posedge clk); #1;
            if (acc) begin k++; in_left = 24'(k); in_right = 24'(-k); end
            if (c == 4) in_valid = 1'b0;
        end
        check("bp_count", 32'(got.size()), 32'(sent.size()));
        errs = 0;
        for (int i = 0; i < sent.size() && i < got.size(); i++)
            if (got[i] !== sent[i]) errs++;
        check("bp_order", 32'(errs), 32'd0);

        // Reset in the middle of backpressure flushes both stages.
        do_reset();
        write_ready = 1'b0;
        in_valid = 1'b1;
        in_left  = 24'h111111;
        in_right = 24'h222222;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("flush_full", 32'(in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_wd", 32'(writedata_left), 32'd0);
        @(posedge clk); #1;
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        write_ready = 1'b1;
        nw = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (write) nw++;
            @(posedge clk); #1;
        end
        check("flush_no_write", 32'(nw), 32'd0);

        // Clip clear versus set on the same cycle; 0x800000 peak folding.
        do_reset();
        gain_sel = 3'd1;
        in_valid = 1'b1;
        in_left  = 24'h400000;
        in_right = 24'h800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_write", 32'(write), 32'd1);
        clip_clr = 1'b1;
        @(posedge clk); #1;
        clip_clr = 1'b0;
        check("clr_set_wins", 32'({clip_left, clip_right}), 32'd3);
        check("peak_fold_l", 32'(peak_left), 32'h7FFFFF);
        check("peak_fold_r", 32'(peak_right), 32'h7FFFFF);
        clip_clr = 1'b1;
        @(posedge clk); #1;
        clip_clr = 1'b0;
        check("clr_alone", 32'({clip_left, clip_right}), 32'd0);

        // Peak hold for 64 writes, then decay; small peak does not decay.
        do_reset();
        in_valid = 1'b1;
        in_left  = 24'h400000;
        in_right = 24'hFFFFF1;
        nw = 0;
        for (int c = 0; c < 90 && nw < 67; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            wr  = write;
            @(posedge clk); #1;
            if (acc) begin in_left = '0; in_right = '0; end
            if (wr) begin
                nw++;
                case (nw)
                    1: begin
                        check("peak_first_l", 32'(peak_left), 32'h400000);
                        check("peak_first_r", 32'(peak_right), 32'h00000F);
                    end
                    65: check("peak_hold_end", 32'(peak_left), 32'h400000);
                    66: check("peak_decay1", 32'(peak_left), 32'h3C0000);
                    67: begin
                        check("peak_decay2", 32'(peak_left), 32'h384000);
                        check("peak_floor_r", 32'(peak_right), 32'h00000F);
                    end
                    default: ;
                endcase
            end
        end
        check("peak_budget", 32'(nw), 32'd67);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
